// File: rtl/jtpopeye_prog_pkg.sv
// Shared definitions for the ROM-download-to-SDRAM write queue.
//   state_t      : request FSM encoding (IDLE waits for a queued entry,
//                  REQ holds a write request until the controller acks it)
//   DQM_RST      : byte-mask value presented while no write is pending
//   ENTRY_EXTRA  : bits stored per queue entry beyond the address (8 data + 2 mask)
//   entry_w()    : full queue entry width for a given address width
package jtpopeye_prog_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  localparam logic [1:0] DQM_RST     = 2'b11;
  localparam int         ENTRY_EXTRA = 8 + 2;

  function automatic int entry_w(input int aw);
    return aw + ENTRY_EXTRA;
  endfunction

endpackage

// File: rtl/jtpopeye_prog_sdram_if.sv
// Bus bundle between the download splitter, the write queue and the SDRAM
// controller.
//   prog_*     : one-cycle write strobe with word address, byte and active-low mask
//   sdram_*    : registered write request towards the SDRAM controller
// Handshake: sdram_wr_req is a valid that stays high, with address/data/mask
// stable, until the cycle in which sdram_ack (the ready) is seen high; that
// cycle completes the transfer. An ack while no request is up means nothing.
// modport slave  : the write queue
// modport master : the download side plus controller (the testbench)
interface jtpopeye_prog_sdram_if #(
  parameter int AW = 22
);
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic [1:0]    prog_mask;
  logic          prog_we;
  logic [AW-1:0] sdram_addr;
  logic [15:0]   sdram_din;
  logic [1:0]    sdram_dqm;
  logic          sdram_wr_req;
  logic          sdram_ack;

  modport slave (
    input  prog_addr, prog_data, prog_mask, prog_we, sdram_ack,
    output sdram_addr, sdram_din, sdram_dqm, sdram_wr_req
  );

  modport master (
    output prog_addr, prog_data, prog_mask, prog_we, sdram_ack,
    input  sdram_addr, sdram_din, sdram_dqm, sdram_wr_req
  );
endinterface

// File: rtl/jtpopeye_prog_fifo.sv
// Small synchronous FIFO with a combinational (show-ahead) read port.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write din_i this cycle (caller guarantees room or a pop)
//   pop_i        : discard the head this cycle (caller guarantees non-empty)
//   dout_o       : head entry, valid whenever empty_o is low
//   full_o       : DEPTH entries stored
//   empty_o      : nothing stored
module jtpopeye_prog_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int IW = $clog2(DEPTH);

  // One extra pointer bit tells a full ring from an empty one.
  logic [IW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[IW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_q[IW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);
endmodule

// File: rtl/jtpopeye_prog_sdram.sv
// Queues ROM download write strobes and replays them as held SDRAM write
// requests, so no byte is lost while the controller is busy.
// Ports:
//   clk_rom     : clock shared with the download path
//   rst         : synchronous active-high reset; abandons queue and request
//   downloading : high during a download; edges drive done/overflow/checksum
//   bus         : prog_* strobe in, sdram_* request out (see interface)
//   busy        : queue not empty or request outstanding
//   overflow    : sticky, a strobe was dropped because the queue was full
//   done        : one-cycle pulse once a finished download has fully drained
//   chksum      : wrapping 16-bit sum of accepted bytes
//                 (only with JTPOPEYE_PROG_CHECKSUM_EN defined)
//   state_dbg   : current request FSM state
module jtpopeye_prog_sdram
  import jtpopeye_prog_pkg::*;
#(
  parameter int AW    = 22,
  parameter int DEPTH = 4
) (
  input  logic                  clk_rom,
  input  logic                  rst,
  input  logic                  downloading,
  jtpopeye_prog_sdram_if.slave  bus,
  output logic                  busy,
  output logic                  overflow,
  output logic                  done,
`ifdef JTPOPEYE_PROG_CHECKSUM_EN
  output logic [15:0]           chksum,
`endif
  output state_t                state_dbg
);
  localparam int EW = entry_w(AW);

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   din_q;
  logic [1:0]    dqm_q;
  logic          req_q;
  logic          dl_q, pending_q, pending_d, overflow_q, overflow_d;
  logic          push, pop, full, empty, dl_rise, dl_fall;
  logic [EW-1:0] fifo_din, fifo_dout;

  // The head stays in the FIFO while its request is out; it leaves on ack.
  assign pop      = (state_q == ST_REQ) && bus.sdram_ack;
  // A full queue can still take a strobe when the head retires this cycle.
  assign push     = bus.prog_we && (!full || pop);
  assign fifo_din = {bus.prog_addr, bus.prog_data, bus.prog_mask};

  jtpopeye_prog_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk_i   (clk_rom),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      dqm_q   <= DQM_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            addr_q  <= fifo_dout[EW-1 -: AW];
            din_q   <= {2{fifo_dout[9:2]}};
            dqm_q   <= fifo_dout[1:0];
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.sdram_ack) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dl_rise = downloading && !dl_q;
  assign dl_fall = !downloading && dl_q;
  // Empty implies IDLE, but both are kept so the intent reads directly.
  assign done    = pending_q && empty && (state_q == ST_IDLE);

  always_comb begin
    pending_d = pending_q;
    if (dl_rise)      pending_d = 1'b0;
    else if (dl_fall) pending_d = 1'b1;
    else if (done)    pending_d = 1'b0;

    overflow_d = overflow_q;
    if (dl_rise)                 overflow_d = 1'b0;
    if (bus.prog_we && !push)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      dl_q       <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      dl_q       <= downloading;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef JTPOPEYE_PROG_CHECKSUM_EN
  logic [15:0] chksum_q, chksum_d;

  // A new download restarts the sum even if a byte arrives in that cycle.
  always_comb begin
    chksum_d = chksum_q;
    if (dl_rise)   chksum_d = '0;
    else if (push) chksum_d = chksum_q + {8'd0, bus.prog_data};
  end

  always_ff @(posedge clk_rom) begin
    if (rst) chksum_q <= '0;
    else     chksum_q <= chksum_d;
  end

  assign chksum = chksum_q;
`endif

  assign bus.sdram_addr   = addr_q;
  assign bus.sdram_din    = din_q;
  assign bus.sdram_dqm    = dqm_q;
  assign bus.sdram_wr_req = req_q;
  assign busy             = !empty || (state_q == ST_REQ);
  assign overflow         = overflow_q;
  assign state_dbg        = state_q;
endmodule

// File: tb/tb_jtpopeye_prog_sdram.sv
module tb_jtpopeye_prog_sdram;
  import jtpopeye_prog_pkg::*;

  localparam int AW    = 22;
  localparam int DEPTH = 4;
  localparam int EW    = AW + 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic downloading = 1'b0;
  always #5 clk = ~clk;

  logic        busy, overflow, done;
  logic [15:0] chksum;
  state_t      state_dbg;

  jtpopeye_prog_sdram_if #(.AW(AW)) bus ();

  logic ack_resp   = 1'b0;
  logic ack_force  = 1'b0;
  logic force_real = 1'b0;
  assign bus.sdram_ack = ack_resp | ack_force;

  jtpopeye_prog_sdram #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk_rom     (clk),
    .rst         (rst),
    .downloading (downloading),
    .bus         (bus),
    .busy        (busy),
    .overflow    (overflow),
    .done        (done),
`ifdef JTPOPEYE_PROG_CHECKSUM_EN
    .chksum      (chksum),
`endif
    .state_dbg   (state_dbg)
  );

`ifndef JTPOPEYE_PROG_CHECKSUM_EN
  assign chksum = 16'd0;
`endif

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // A write queue of capacity DEPTH: an entry lives from acceptance until
  // the controller acks its request. Strobes beyond capacity are dropped.
  logic [EW-1:0] exp_q[$];
  logic          m_ov = 1'b0, m_pend = 1'b0, m_dl = 1'b0;
  logic [15:0]   m_chk = 16'd0;
  logic          m_pop, m_acc, m_rise, m_fall, m_done;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_ov = 1'b0; m_pend = 1'b0; m_dl = 1'b0; m_chk = 16'd0;
    end else begin
      m_rise = downloading && !m_dl;
      m_fall = !downloading && m_dl;
      m_done = m_pend && (exp_q.size() == 0);
      m_pop  = ack_resp || (ack_force && force_real);
      m_acc  = bus.prog_we && ((exp_q.size() < DEPTH) || m_pop);
      if (m_pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back({bus.prog_addr, bus.prog_data, bus.prog_mask});
      if (m_rise) m_chk = 16'd0;
      else if (m_acc) m_chk = m_chk + {8'd0, bus.prog_data};
      if (m_rise) m_ov = 1'b0;
      if (bus.prog_we && !m_acc) m_ov = 1'b1;
      if (m_rise) m_pend = 1'b0;
      else if (m_fall) m_pend = 1'b1;
      else if (m_done) m_pend = 1'b0;
      m_dl = downloading;
    end
  end

  // ---------------- monitor / controller responder ----------------
  int   lat_lo = 0, lat_hi = 0, rcnt = 0, rtarget = 0;
  int   req_rises = 0, done_cnt = 0;
  logic req_prev = 1'b0;
  logic [EW-1:0] head;

  always @(negedge clk) begin
    ack_resp = 1'b0;
    if (rst) begin
      rcnt = 0;
      req_prev = 1'b0;
    end else begin
      check("busy", busy, exp_q.size() != 0);
      check("overflow", overflow, m_ov);
      check("done", done, m_pend && (exp_q.size() == 0));
`ifdef JTPOPEYE_PROG_CHECKSUM_EN
      check("chksum", chksum, m_chk);
`endif
      if (done) done_cnt++;
      if (exp_q.size() == 0) check("req_without_entry", bus.sdram_wr_req, 1'b0);
      if (bus.sdram_wr_req) begin
        if (!req_prev) req_rises++;
        if (exp_q.size() != 0) begin
          head = exp_q[0];
          check("sdram_addr", bus.sdram_addr, head[EW-1 -: AW]);
          check("sdram_din", bus.sdram_din, {head[9:2], head[9:2]});
          check("sdram_dqm", bus.sdram_dqm, head[1:0]);
        end
        if (rcnt == 0) rtarget = $urandom_range(lat_hi, lat_lo);
        if (rcnt >= rtarget) begin
          ack_resp = 1'b1;
          rcnt = 0;
        end else rcnt++;
      end else rcnt = 0;
      req_prev = bus.sdram_wr_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic [AW-1:0] a, input logic [7:0] d, input logic [1:0] m);
    bus.prog_addr = a;
    bus.prog_data = d;
    bus.prog_mask = m;
    bus.prog_we   = 1'b1;
    @(negedge clk);
    bus.prog_we   = 1'b0;
  endtask

  task automatic rand_strobe();
    strobe(AW'($urandom), 8'($urandom), 2'($urandom_range(3, 0)));
  endtask

  task automatic drain(input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_req(input int max);
    int k = 0;
    while (!bus.sdram_wr_req && k < max) begin
      @(negedge clk);
      k++;
    end
    if (!bus.sdram_wr_req) fail_now("wait_req_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, bus.sdram_addr, '0);
    check({tag, "_din"}, bus.sdram_din, 16'h0000);
    check({tag, "_dqm"}, bus.sdram_dqm, 2'b11);
    check({tag, "_req"}, bus.sdram_wr_req, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  int base;

  initial begin
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.prog_mask = 2'b11;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    downloading = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single strobe, request two cycles later, ack after 3 cycles
    lat_lo = 3; lat_hi = 3;
    strobe(22'h00123, 8'hA5, 2'b10);
    check("t1_req_n1", bus.sdram_wr_req, 1'b0);
    @(negedge clk);
    check("t1_req_n2", bus.sdram_wr_req, 1'b1);
    check("t1_addr", bus.sdram_addr, 22'h00123);
    check("t1_din", bus.sdram_din, 16'hA5A5);
    check("t1_dqm", bus.sdram_dqm, 2'b10);
    drain(50);
    check("t1_busy_after", busy, 1'b0);

    // 2: burst of 8 against a slow controller
    lat_lo = 20; lat_hi = 20;
    base = req_rises;
    for (int i = 0; i < 8; i++) rand_strobe();
    check("t2_overflow", overflow, 1'b1);
    drain(400);
    check("t2_requests", req_rises - base, 4);
    downloading = 1'b0; @(negedge clk);
    downloading = 1'b1; @(negedge clk);
    check("t2_overflow_cleared", overflow, 1'b0);

    // 3: strobe into a full queue in the cycle the head is acked
    lat_lo = 1000; lat_hi = 1000;
    base = req_rises;
    for (int i = 0; i < 4; i++) rand_strobe();
    wait_req(20);
    ack_force = 1'b1; force_real = 1'b1;
    strobe(22'h3ABCDE, 8'h5C, 2'b01);
    ack_force = 1'b0; force_real = 1'b0;
    check("t3_overflow", overflow, 1'b0);
    lat_lo = 1; lat_hi = 1;
    drain(100);
    check("t3_requests", req_rises - base, 5);

    // 4: download ends with 3 entries queued
    lat_lo = 2; lat_hi = 2;
    base = done_cnt;
    for (int i = 0; i < 3; i++) rand_strobe();
    downloading = 1'b0;
    drain(100);
    repeat (3) @(negedge clk);
    check("t4_done_pulses", done_cnt - base, 1);
    downloading = 1'b1;
    @(negedge clk);

    // 5: reset while a request is up, then a stray ack
    lat_lo = 1000; lat_hi = 1000;
    rand_strobe();
    wait_req(20);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5");
    rst = 1'b0;
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_no_req", bus.sdram_wr_req, 1'b0);
    end

    // random traffic with varying controller latency and download edges
    lat_lo = 0; lat_hi = 4;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(49, 0) == 0) downloading = ~downloading;
      if ($urandom_range(2, 0) == 0) rand_strobe();
      else @(negedge clk);
    end
    downloading = 1'b1;
    drain(200);

`ifdef JTPOPEYE_PROG_CHECKSUM_EN
    // 6: checksum over a fresh download
    downloading = 1'b0; @(negedge clk);
    downloading = 1'b1; @(negedge clk);
    check("t6_chk_start", chksum, 16'h0000);
    strobe(22'h10, 8'hFF, 2'b10);
    strobe(22'h11, 8'h02, 2'b01);
    strobe(22'h12, 8'h10, 2'b10);
    drain(100);
    check("t6_chk_sum", chksum, 16'h0111);
    downloading = 1'b0; @(negedge clk);
    downloading = 1'b1; @(negedge clk);
    check("t6_chk_cleared", chksum, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    fail_now("watchdog");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
